// File: rtl/idex_pipe_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: control-flag bit positions,
// ALU op encodings and default field widths.
package idex_pipe_reg_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_NUM_SRC = 2;
    localparam int DEF_RADDR_W = 4;
    localparam int DEF_FUNCT_W = 4;
    localparam int DEF_ALUOP_W = 2;
    localparam int DEF_CTRL_W  = 7;
    localparam int DEF_CNT_W   = 16;

    // Bit positions inside the control bundle {R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch}
    localparam int CTRL_R15      = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

endpackage

// File: rtl/idex_pipe_reg_slot.sv
// Generic payload register with a valid bit. An empty load or a clear also zeroes
// the payload, so an invalid slot never carries live control bits.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         valid_d_i,
    input  logic [W-1:0] data_d_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_d_i;
            data_q  <= valid_d_i ? data_d_i : '0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX stage buffer with a valid/ready handshake, one-entry skid behind the output
// register, flush-to-bubble and a saturating bubble-cycle counter.
module idex_pipe_reg
    import idex_pipe_reg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int FUNCT_W = DEF_FUNCT_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] in_rd,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [RADDR_W-1:0]        in_rs,
    input  logic [RADDR_W-1:0]        in_rt,
    input  logic [FUNCT_W-1:0]        in_funct,
    input  logic [ALUOP_W-1:0]        in_aluop,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_SRC*DATA_W-1:0] out_rd,
    output logic [DATA_W-1:0]         out_imm,
    output logic [RADDR_W-1:0]        out_rs,
    output logic [RADDR_W-1:0]        out_rt,
    output logic [FUNCT_W-1:0]        out_funct,
    output logic [ALUOP_W-1:0]        out_aluop,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int PW = CTRL_W + ALUOP_W + FUNCT_W + 2*RADDR_W + DATA_W + NUM_SRC*DATA_W;

    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;
    logic [PW-1:0]    skid_payload;
    logic             skid_valid;
    logic             accept;
    logic             out_free;
    logic             out_load_d;
    logic             out_valid_d;
    logic [PW-1:0]    out_data_d;
    logic             skid_load_d;
    logic             skid_valid_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    assign in_payload = {in_ctrl, in_aluop, in_funct, in_rt, in_rs, in_imm, in_rd};

    // Handshake: a beat moves on a rising edge where valid & ready are both high;
    // ready never depends combinationally on valid, and flush overrides both sides.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign out_free = !out_valid || out_ready;

    always_comb begin
        out_load_d   = out_free;
        out_valid_d  = skid_valid || accept;
        out_data_d   = skid_valid ? skid_payload : in_payload;
        skid_load_d  = (skid_valid && out_free) || (accept && !out_free);
        skid_valid_d = accept && !out_free;
    end

    pipe_skid_slot #(.W(PW)) u_out_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (out_load_d),
        .clear_i   (flush),
        .valid_d_i (out_valid_d),
        .data_d_i  (out_data_d),
        .valid_o   (out_valid),
        .data_o    (out_payload)
    );

    pipe_skid_slot #(.W(PW)) u_skid_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (skid_load_d),
        .clear_i   (flush),
        .valid_d_i (skid_valid_d),
        .data_d_i  (in_payload),
        .valid_o   (skid_valid),
        .data_o    (skid_payload)
    );

    assign {out_ctrl, out_aluop, out_funct, out_rt, out_rs, out_imm, out_rd} = out_payload;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_cnt_q <= '0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: pass-through, skid stall, flush, bubble counter
// saturation and asynchronous reset while stalled.
module tb_idex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rd;
    logic [15:0] in_imm;
    logic [3:0]  in_rs;
    logic [3:0]  in_rt;
    logic [3:0]  in_funct;
    logic [1:0]  in_aluop;
    logic [6:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;
    logic [15:0] out_imm;
    logic [3:0]  out_rs;
    logic [3:0]  out_rt;
    logic [3:0]  out_funct;
    logic [1:0]  out_aluop;
    logic [6:0]  out_ctrl;
    logic [15:0] bubble_cnt;

    logic        in_ready3;
    logic        out_valid3;
    logic [31:0] out_rd3;
    logic [15:0] out_imm3;
    logic [3:0]  out_rs3;
    logic [3:0]  out_rt3;
    logic [3:0]  out_funct3;
    logic [1:0]  out_aluop3;
    logic [6:0]  out_ctrl3;
    logic [2:0]  bubble_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
        .in_funct(in_funct), .in_aluop(in_aluop), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_imm(out_imm), .out_rs(out_rs), .out_rt(out_rt),
        .out_funct(out_funct), .out_aluop(out_aluop), .out_ctrl(out_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    idex_pipe_reg #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_rd(in_rd), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
        .in_funct(in_funct), .in_aluop(in_aluop), .in_ctrl(in_ctrl),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_rd(out_rd3), .out_imm(out_imm3), .out_rs(out_rs3), .out_rt(out_rt3),
        .out_funct(out_funct3), .out_aluop(out_aluop3), .out_ctrl(out_ctrl3),
        .bubble_cnt(bubble_cnt3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rd = '0; in_imm = '0; in_rs = '0; in_rt = '0;
        in_funct = '0; in_aluop = '0; in_ctrl = '0;

        // reset values
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_bubble", 64'(bubble_cnt), 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_aluop", 64'(out_aluop), 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);

        // idle 10 cycles with out_ready high
        #9;
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (10) step();
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("bubble_10", 64'(bubble_cnt), 64'd10);
        check("bubble_sat3", 64'(bubble_cnt3), 64'd7);

        // first instruction passes straight through
        in_valid = 1'b1; in_rd = {16'd7, 16'd3}; in_imm = 16'd8; in_rs = 4'd9; in_rt = 4'd4;
        in_funct = 4'd2; in_aluop = 2'd3; in_ctrl = 7'b1011000;
        step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_rd", 64'(out_rd), 64'h0007_0003);
        check("t1_imm", 64'(out_imm), 64'd8);
        check("t1_rs", 64'(out_rs), 64'd9);
        check("t1_rt", 64'(out_rt), 64'd4);
        check("t1_funct", 64'(out_funct), 64'd2);
        check("t1_aluop", 64'(out_aluop), 64'd3);
        check("t1_ctrl", 64'(out_ctrl), 64'b1011000);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t1_bubble", 64'(bubble_cnt), 64'd11);

        // stall: second instruction lands in the skid
        out_ready = 1'b0; in_rd = {16'd7, 16'd5}; in_aluop = 2'd1; in_ctrl = 7'b0001001;
        step();
        check("st_in_ready", 64'(in_ready), 64'd0);
        check("st_hold_rd1", 64'(out_rd[15:0]), 64'd3);
        check("st_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        check("st_hold2_rd1", 64'(out_rd[15:0]), 64'd3);
        check("st_in_ready2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("drain_valid", 64'(out_valid), 64'd1);
        check("drain_rd1", 64'(out_rd[15:0]), 64'd5);
        check("drain_ctrl", 64'(out_ctrl), 64'b0001001);
        check("drain_aluop", 64'(out_aluop), 64'd1);
        check("drain_in_ready", 64'(in_ready), 64'd1);
        step();
        check("empty_valid", 64'(out_valid), 64'd0);
        check("empty_ctrl", 64'(out_ctrl), 64'd0);
        check("empty_aluop", 64'(out_aluop), 64'd0);
        check("empty_bubble", 64'(bubble_cnt), 64'd11);

        // flush with both slots full
        out_ready = 1'b0; in_valid = 1'b1; in_rd = {16'd0, 16'h11}; in_aluop = 2'd2; in_ctrl = 7'b1011000;
        step();
        check("f_out_loaded", 64'(out_rd[15:0]), 64'h11);
        in_rd = {16'd0, 16'h22};
        step();
        check("f_skid_full", 64'(in_ready), 64'd0);
        flush = 1'b1; in_valid = 1'b0;
        step();
        check("f_valid", 64'(out_valid), 64'd0);
        check("f_ctrl", 64'(out_ctrl), 64'd0);
        check("f_aluop", 64'(out_aluop), 64'd0);
        check("f_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; out_ready = 1'b1;
        step();
        check("f_skid_empty", 64'(out_valid), 64'd0);
        check("f_bubble", 64'(bubble_cnt), 64'd12);

        // flush drops a concurrently presented input
        flush = 1'b1; in_valid = 1'b1; in_rd = {16'd0, 16'h33}; in_ctrl = 7'b0000100; in_aluop = 2'd1;
        step();
        check("fi_valid", 64'(out_valid), 64'd0);
        check("fi_ctrl", 64'(out_ctrl), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fi_dropped", 64'(out_valid), 64'd0);
        check("fi_bubble", 64'(bubble_cnt), 64'd14);

        // asynchronous reset while stalled with the skid full
        out_ready = 1'b0; in_valid = 1'b1; in_rd = {16'd0, 16'h44}; in_ctrl = 7'b0001000; in_aluop = 2'd2;
        step();
        check("ar_loaded", 64'(out_valid), 64'd1);
        in_rd = {16'd0, 16'h55};
        step();
        check("ar_skid_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_bubble", 64'(bubble_cnt), 64'd0);
        check("ar_bubble3", 64'(bubble_cnt3), 64'd0);
        check("ar_ctrl", 64'(out_ctrl), 64'd0);
        check("ar_aluop", 64'(out_aluop), 64'd0);
        check("ar_rd", 64'(out_rd), 64'd0);
        check("ar_imm", 64'(out_imm), 64'd0);
        #2;
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        check("ar_skid_lost", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_pipe_reg.md
Name: idex_pipe_reg

Overview:
Parametrised successor to the fixed-width ID/EX stage buffer. Registers the decoded operands, immediate, register specifiers, funct code and control bundle between the decode and execute stages. Adds a valid/ready handshake with a 2-entry skid buffer so that an execute-side stall never drops an instruction. Also adds flush-to-bubble and a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 16, operand and immediate width
NUM_SRC, 2, number of source operand lanes (RD1, RD2, ...)
RADDR_W, 4, register-specifier width (RS/RT)
FUNCT_W, 4, funct code width
ALUOP_W, 2, ALU op width
CTRL_W, 7, single-bit control flags {R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch}
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash stage contents (branch taken / hazard)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept; registered
in_rd  in  NUM_SRC*DATA_W  source operands, lane 0 in the LSBs
in_imm  in  DATA_W  sign-extended immediate
in_rs  in  RADDR_W  source register specifier
in_rt  in  RADDR_W  target register specifier
in_funct  in  FUNCT_W  funct code
in_aluop  in  ALUOP_W  ALU op
in_ctrl  in  CTRL_W  control flags
out_valid  out  1  execute-side instruction valid
out_ready  in  1  execute accepts (low = stall)
out_rd, out_imm, out_rs, out_rt, out_funct, out_aluop, out_ctrl  out  widths as the matching inputs  registered copies
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid_valid=0, in_ready=1, bubble_cnt=0, all out_* data=0, out_ctrl=0, out_aluop=0.
- Input accept: in_valid & in_ready at the rising edge.
- Output transfer: out_valid & out_ready at the rising edge.
- Output register loads when (!out_valid | out_ready). Source is the skid entry if skid_valid, otherwise the input if accepted. out_valid follows the source.
- Latency: an accepted instruction appears on out_* in the next cycle when the output register is free or draining.
- Stall: an input accepted while out_valid & !out_ready goes to the skid entry. in_ready deasserts the next cycle. No data loss; order is preserved.
- in_ready = !skid_valid (registered).
- Skid drains into the output register on the first cycle out_ready=1. in_ready reasserts the following cycle.
- Simultaneous accept and transfer with empty skid: pass-through; skid stays empty.
- Flush (synchronous, highest priority over every other event):
  - next cycle out_valid=0, skid_valid=0, in_ready=1;
  - out_ctrl and out_aluop forced to 0;
  - data fields may hold stale values;
  - an input presented in the flush cycle is discarded.
- Bubble rule: whenever out_valid=0, out_ctrl=0 and out_aluop=0, so no write-back or memory side effect can leak.
- bubble_cnt: +1 each cycle with out_valid=0 & out_ready=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-stall: everything is cleared immediately (async), and the skid contents are lost.

Decomposition:
- Shared package: CTRL bit index constants (CTRL_R15..CTRL_BRANCH), ALUOP encodings, default widths.
- Sub-module pipe_skid_slot: a generic DATA-wide register with valid, load and clear. Instantiate it twice (output slot, skid slot), with the payload concatenated into one vector.

Test Plan:
- Reset, then in_valid=1, in_rd={7,3}, in_imm=8, in_rs=9, in_rt=4, in_funct=2, in_aluop=3, in_ctrl=7'b1011000, out_ready=1 -> next cycle out_valid=1 with identical fields.
- Stall: out_ready=0 with out_valid=1, push a second instruction (RD1=5) -> in_ready=0 next cycle. Raise out_ready -> RD1=3 leaves first, then RD1=5, with no loss or duplication.
- Flush while both slots are full -> next cycle out_valid=0, out_ctrl=0, out_aluop=0, in_ready=1, and the skid is empty.
- Flush together with in_valid=1 -> the input is dropped, and out_valid=0 next cycle.
- Idle with out_ready=1 for 10 cycles after reset -> bubble_cnt=10. With CNT_W=3 over 10 cycles -> bubble_cnt=7 (saturated).
- rst_n pulsed low asynchronously mid-stall -> all outputs reach their reset values before the next clk edge.
